// File: rtl/seq_detector_param.sv
// Serial pattern detector: runtime-loadable N-bit pattern, overlap/non-overlap modes,
// registered match pulse and saturating counter. Sticky flag gated by SEQ_DETECTOR_STICKY_EN.
module seq_detector_param #(
  parameter int unsigned  N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter int unsigned  CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             overlap,
  input  logic             pattern_ld,
  input  logic [N-1:0]     pattern_in,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             match_flag,
  input  logic             flag_clr
);

  localparam int unsigned     FW       = $clog2(N + 1);
  localparam logic [FW-1:0]   FILL_MAX = FW'(N);

  logic [N-1:0]     pattern_q, pattern_d;
  logic [N-1:0]     hist_q, hist_d, hist_next;
  logic [FW-1:0]    fill_q, fill_d, fill_next;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  always_comb begin
    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = 1'b0;
    hit       = 1'b0;
    hist_next = {hist_q[N-2:0], din};
    fill_next = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;

    if (pattern_ld) begin
      // A new target invalidates any partial history; same-cycle sample is dropped.
      pattern_d = pattern_in;
      hist_d    = '0;
      fill_d    = '0;
    end else if (en) begin
      hit     = (fill_next == FILL_MAX) && (hist_next == pattern_q);
      hist_d  = hist_next;
      fill_d  = (hit && !overlap) ? '0 : fill_next;
      match_d = hit;
    end

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_q <= PATTERN;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;

`ifdef SEQ_DETECTOR_STICKY_EN
  logic flag_q;

  // Set has priority over clear so a coincident hit is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_q <= 1'b0;
    end else if (hit) begin
      flag_q <= 1'b1;
    end else if (flag_clr) begin
      flag_q <= 1'b0;
    end
  end

  assign match_flag = flag_q;
`else
  logic unused_flag_clr;
  assign unused_flag_clr = flag_clr;
  assign match_flag      = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed + random bench for seq_detector_param against a queue-based reference model.
module tb_seq_detector_param;

  localparam int unsigned N       = 4;
  localparam int unsigned CNT_W   = 8;
  localparam logic [3:0]  DEF_PAT = 4'b1011;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en, din, overlap, pattern_ld, cnt_clr, flag_clr;
  logic [N-1:0]     pattern_in;
  logic             match, match_flag;
  logic [CNT_W-1:0] match_cnt;

  seq_detector_param #(
    .N       (N),
    .PATTERN (DEF_PAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .overlap    (overlap),
    .pattern_ld (pattern_ld),
    .pattern_in (pattern_in),
    .cnt_clr    (cnt_clr),
    .match      (match),
    .match_cnt  (match_cnt),
    .match_flag (match_flag),
    .flag_clr   (flag_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: bits received since the last clear, current target, counts.
  bit         m_bits[$];
  logic [3:0] m_pat;
  int         m_cnt;
  bit         m_match;
  bit         m_flag;

  function automatic bit window_hit();
    int w = 0;
    if (m_bits.size() < N) return 1'b0;
    for (int i = 0; i < int'(N); i++) w = w * 2 + int'(m_bits[m_bits.size() - N + i]);
    return w == int'(m_pat);
  endfunction

  task automatic check(input string tag);
    bit exp_flag;
`ifdef SEQ_DETECTOR_STICKY_EN
    exp_flag = m_flag;
`else
    exp_flag = 1'b0;
`endif
    tests++;
    assert (match === m_match) else begin
      fails++;
      $error("FAIL %s match got %0b want %0b", tag, match, m_match);
    end
    tests++;
    assert (match_cnt === CNT_W'(m_cnt)) else begin
      fails++;
      $error("FAIL %s match_cnt got %0d want %0d", tag, match_cnt, m_cnt);
    end
    tests++;
    assert (match_flag === exp_flag) else begin
      fails++;
      $error("FAIL %s match_flag got %0b want %0b", tag, match_flag, exp_flag);
    end
  endtask

  task automatic check_const(input string tag, input bit exp_m, input int exp_c);
    tests++;
    assert (match === exp_m && match_cnt === CNT_W'(exp_c)) else begin
      fails++;
      $error("FAIL %s match/cnt got %0b/%0d want %0b/%0d", tag, match, match_cnt, exp_m, exp_c);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_pat   = DEF_PAT;
    m_cnt   = 0;
    m_match = 1'b0;
    m_flag  = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, then check just after the edge.
  task automatic step(input string tag, input bit e, input bit d, input bit ld = 1'b0,
                      input logic [3:0] pin = 4'b0, input bit cc = 1'b0, input bit fc = 1'b0);
    bit hit = 1'b0;
    en = e; din = d; pattern_ld = ld; pattern_in = pin; cnt_clr = cc; flag_clr = fc;
    if (ld) begin
      m_pat = pin;
      m_bits.delete();
    end else if (e) begin
      m_bits.push_back(d);
      if (m_bits.size() > N) void'(m_bits.pop_front());
      hit = window_hit();
      if (hit && !overlap) m_bits.delete();
    end
    m_match = hit;
    if (cc) m_cnt = 0;
    else if (hit && m_cnt < CNT_MAX) m_cnt++;
    if (hit) m_flag = 1'b1;
    else if (fc) m_flag = 1'b0;
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic send(input string tag, input logic [3:0] bits, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) step(tag, 1'b1, bits[i]);
  endtask

  initial begin
    logic [6:0] s7;
    rst = 1'b0; en = 0; din = 0; overlap = 1; pattern_ld = 0; pattern_in = '0;
    cnt_clr = 0; flag_clr = 0;
    model_reset();
    #12;
    check("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Overlapping: 1011011 matches after bits 4 and 7.
    overlap = 1'b1;
    s7 = 7'b1011011;
    for (int i = 6; i >= 0; i--) step("ovl", 1'b1, s7[i]);
    check_const("ovl_cnt", 1'b1, 2);
    step("ovl_idle", 1'b0, 1'b0);
    check_const("ovl_pulse_end", 1'b0, 2);
    step("clr", 1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 1'b1);

    // Non-overlapping: history discarded after first match.
    overlap = 1'b0;
    step("reload", 1'b0, 1'b0, 1'b1, DEF_PAT);
    for (int i = 6; i >= 0; i--) step("novl", 1'b1, s7[i]);
    check_const("novl_cnt", 1'b0, 1);

    // en gaps between qualified bits.
    overlap = 1'b1;
    step("reload2", 1'b0, 1'b0, 1'b1, DEF_PAT);
    for (int i = 3; i >= 0; i--) begin
      step("gap_bit", 1'b1, DEF_PAT[i]);
      if (i > 0) begin
        step("gap", 1'b0, ~DEF_PAT[i]);
        step("gap", 1'b0, DEF_PAT[i]);
      end
    end
    check_const("gap_hit", 1'b1, 2);

    // Pattern load mid-stream drops the coincident bit and the partial history.
    send("pre_ld", 4'b0101, 3);
    step("ld", 1'b1, 1'b1, 1'b1, 4'b0110);
    send("new_pat", 4'b0110, 4);
    check_const("new_pat_hit", 1'b1, 3);
    send("old_pat", 4'b1011, 4);
    step("flag_only_clr", 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1);

    // Mid-stream asynchronous reset between edges.
    step("ld_def", 1'b0, 1'b0, 1'b1, DEF_PAT);
    send("pre_rst", 4'b0101, 3);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_rst");
    rst = 1'b1;
    send("post_rst", 4'b0011, 2);
    send("post_rst_full", 4'b1011, 4);
    check_const("post_rst_hit", 1'b1, 1);

    // Saturation with all-ones pattern, then cnt_clr + flag_clr on a hit.
    step("ld_ones", 1'b0, 1'b0, 1'b1, 4'b1111);
    for (int i = 0; i < 270; i++) step("sat", 1'b1, 1'b1);
    check_const("sat_hold", 1'b1, CNT_MAX);
    step("clr_on_hit", 1'b1, 1'b1, 1'b0, 4'b0, 1'b1, 1'b1);
    check_const("clr_on_hit_c", 1'b1, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      int r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 15) == 0) overlap = ~overlap;
      step("rand", r >= 3 && r < 80, 1'($urandom), r < 3, 4'($urandom_range(0, 15)),
           $urandom_range(0, 40) == 0, $urandom_range(0, 6) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised successor to the fixed serial sequence detector.
- Detects an N-bit pattern in a gated serial bit stream. The pattern is runtime-loadable.
- Supports overlapping and non-overlapping match modes, a registered match pulse and a saturating match counter.
- Sits on the serial-input side of the FSM lab designs. Drives status LEDs or downstream control FSMs.

Parameters:
- N, 4: pattern length in bits (2..16).
- PATTERN, 4'b1011: reset/default pattern, N bits wide. MSB is the oldest bit received.
- CNT_W, 8: width of the match counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample strobe; din is consumed only when en=1.
- din  input  1  serial data bit.
- overlap  input  1  1 = overlapping matches allowed; 0 = history discarded after each match.
- pattern_ld  input  1  load pattern_in as the new target pattern.
- pattern_in  input  N  new pattern value.
- cnt_clr  input  1  synchronous clear of match_cnt.
- match  output  1  one-cycle pulse per detected pattern.
- match_cnt  output  CNT_W  number of matches, saturating.
- match_flag  output  1  sticky match indicator (see Optional Feature).
- flag_clr  input  1  clears match_flag (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - pattern_reg=PATTERN, hist=0, fill=0.
  - match=0, match_cnt=0, match_flag=0.
- Internal state:
  - hist[N-1:0] shift register.
  - fill counter, clog2(N+1) bits, range 0..N.
  - State is implied by fill: EMPTY (fill=0), FILLING (0<fill<N), FULL (fill=N).
- Per rising edge, priority order pattern_ld > en:
  - pattern_ld=1:
    - pattern_reg<=pattern_in, fill<=0, hist<=0, match<=0.
    - Any en/din in the same cycle is ignored.
    - match_cnt unaffected (except cnt_clr).
  - en=1, pattern_ld=0:
    - hist_next={hist[N-2:0],din}.
    - fill_next=min(fill+1,N).
    - hit = (fill_next==N) and (hist_next==pattern_reg).
    - hist<=hist_next.
    - If hit and overlap=0: fill<=0. Otherwise fill<=fill_next.
    - match<=hit.
  - en=0, pattern_ld=0: hist and fill hold, match<=0.
- Latency:
  - match is asserted the cycle after the edge that sampled the final pattern bit.
  - Pulse width is exactly 1 cycle.
  - Back-to-back pulses are possible in overlap mode.
- Counter:
  - On hit, match_cnt<=match_cnt+1, saturating at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 forces match_cnt<=0. cnt_clr wins over a simultaneous hit.
  - match still pulses when cnt_clr and hit coincide.
- Mode change: overlap is sampled on each en cycle. Changing it does not alter hist or fill.
- The pattern comparison always uses pattern_reg, never pattern_in directly.
- Reset mid-stream: all state is lost immediately, and pattern_reg returns to PATTERN.

Optional Feature:
- Macro: SEQ_DETECTOR_STICKY_EN.
- Defined:
  - match_flag<=1 on any hit and stays set until flag_clr=1.
  - hit and flag_clr in the same cycle: flag stays 1 (set wins).
  - pattern_ld does not clear match_flag.
- Undefined: match_flag is tied to 0 and flag_clr is ignored. The ports remain present.

Test Plan:
- N=4, PATTERN=1011, overlap=1, en=1 continuously, din=1,0,1,1,0,1,1 -> match pulses the cycle after the 4th and 7th bits; match_cnt=2.
- Same stream, overlap=0 -> match only after the 4th bit (trailing 0,1,1 is only 3 bits); match_cnt=1.
- en gaps: bits 1,0,1,1 each separated by 2 cycles of en=0 -> single match pulse after the 4th en-qualified bit; no pulse during the gaps.
- After 3 bits 1,0,1: pattern_ld with pattern_in=0110 and din=1, en=1 in the same cycle -> fill=0, that bit ignored. Then 0,1,1,0 -> match; 1011 no longer detected.
- CNT_W=2, overlap=1, stream 1011011011011011 (5 matches) -> match_cnt=3, held. cnt_clr asserted on the cycle of a hit -> match_cnt=0, match still pulses.
- Reset mid-stream after 1,0,1, rst=0 between edges -> match_cnt, match and fill go to 0 immediately. After release, 1,1 does not match; a full 1011 then matches.
- With SEQ_DETECTOR_STICKY_EN: a match sets match_flag. flag_clr together with a hit keeps match_flag=1; flag_clr alone clears it.
